delay_prog_sched: RTL and testbench
===================================

Name: delay_prog_sched

Overview:
- Sequencer in front of the three SY89297 serial delay programmers. Holds host shadow copies of each channel's dataa/datab pair and detects updates.
- Serializes programming so only one chip is loaded at a time: issues the programmer start pulse, waits for its ready, then moves on round-robin.
- Sits between the host register file and the three delay_ctrl instances.

Parameters:
- RST_CYC, 4, start-pulse width on ctl_rst[i], in clk cycles (1..15)
- BLANK_CYC, 8, cycles after pulse end before ctl_rdy is sampled (1..255)
- TIMEOUT, 4096, max cycles in WAIT_RDY before abort (2..65535)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- host_wr  in  3  per-channel write strobe (bit i = channel i+1), 1 cycle
- host_dataa  in  30  channel i dataa at [10i+9:10i]
- host_datab  in  30  channel i datab at [10i+9:10i]
- force_all  in  1  1-cycle strobe: mark all channels pending
- ctl_dataa  out  30  dataa driven to programmer i
- ctl_datab  out  30  datab driven to programmer i
- ctl_rst  out  3  start pulse to programmer i
- ctl_rdy  in  3  rstRDY from programmer i; high = idle/complete
- pend  out  3  channel has an unapplied update
- busy  out  1  FSM not in IDLE
- done  out  3  1-cycle pulse when channel i finished OK
- err  out  3  sticky timeout flag per channel; cleared by host_wr to that channel

Behaviour:
- Reset (async, rst_n low): all outputs 0. Shadows, ctl_data, pend, err and counters cleared. RR pointer = channel 3, so channel 1 is served first. Reset mid-operation aborts immediately and ctl_rst drops.
- Shadow capture: host_wr[i] copies the host_dataa/datab slice into shadow i and sets pend[i] on the next edge. Writes while pending overwrite the shadow (last value wins).
- force_all sets pend to 3'b111. It is ORed with host_wr.
- Pend clear has lower priority than a set in the same cycle.
- FSM states: IDLE, LOAD, PULSE, BLANK, WAIT_RDY, FINISH.
  - IDLE: if pend != 0, select the first pending channel after the RR pointer (wrap 3 to 1). Go to LOAD.
  - LOAD (1 cycle): copy shadow[ch] into ctl_dataa/ctl_datab[ch] and clear pend[ch]. The other channels' ctl_data are unchanged.
  - PULSE: ctl_rst[ch] = 1 for exactly RST_CYC cycles.
  - BLANK: ctl_rst = 0, wait BLANK_CYC cycles.
  - WAIT_RDY: on ctl_rdy[ch] = 1, go to FINISH. After TIMEOUT cycles, set err[ch] and go to FINISH without done.
  - FINISH (1 cycle): done[ch] = 1 unless timed out. RR pointer = ch. Return to IDLE.
- ctl_data[ch] is held stable from LOAD until the channel is next loaded. A host_wr to the active channel only updates the shadow and sets pend[ch], so the channel is reprogrammed in a later pass.
- Latency: host_wr to ctl_rst rise = 3 cycles when idle (capture, IDLE decision, LOAD).
- At most one ctl_rst bit is high at any time. ctl_rst is registered (glitch-free).
- ctl_rdy of non-selected channels is ignored.
- Counter is 16 bits and saturates; no wrap.

Optional Feature:
- Macro: DELAY_SKIP_SAME_EN.
- Defined: a per-channel last-programmed register is loaded in LOAD. host_wr[i] sets pend[i] only if the new value differs from the last-programmed value or from the current shadow. force_all always sets pend. err clears on any host_wr.
- Undefined: every host_wr sets pend, and no compare logic is built.

Test Plan:
- Reset, host_wr=3'b001, dataa1=10'h155, datab1=10'h0AA, ctl_rdy tied 1 -> ctl_rst[0] high 4 cycles starting cycle 3; ctl_dataa[9:0]=155; done[0] pulses at cycle 3+4+8+1+1; pend=0.
- force_all with ctl_rdy=1 -> pulses in order ch1, ch2, ch3, never overlapping; three done pulses; busy low after the third FINISH.
- Serve ch2, then host_wr=3'b101 while busy -> order after ch2 is ch3, then ch1 (RR); ch2 is not repeated.
- Hold ctl_rdy[1]=0, program ch2 -> after 4+8+4096 cycles err[1]=1 and no done[1]; the FSM then serves the next pending channel; host_wr[1] clears err[1].
- host_wr[0] with a new value during ch1 WAIT_RDY -> ctl_dataa[9:0] unchanged until FINISH; ch1 reprogrammed with the new value afterwards.
- Drop rst_n during PULSE -> ctl_rst=0 asynchronously; all outputs 0. With DELAY_SKIP_SAME_EN, rewriting the identical value after done -> pend stays 0.

Source files
------------

// File: rtl/delay_prog_sched_if.sv
// delay_prog_sched_if: host-side and programmer-side signal bundle for delay_prog_sched
//   host_wr/host_dataa/host_datab/force_all : host shadow writes and force-reprogram strobe
//   ctl_dataa/ctl_datab/ctl_rst/ctl_rdy     : links to the three serial delay programmers
//   pend/busy/done/err                      : sequencer status back to the host
//   master = host/programmer side, slave = sequencer side
interface delay_prog_sched_if;
  logic [2:0]  host_wr;
  logic [29:0] host_dataa;
  logic [29:0] host_datab;
  logic        force_all;
  logic [29:0] ctl_dataa;
  logic [29:0] ctl_datab;
  logic [2:0]  ctl_rst;
  logic [2:0]  ctl_rdy;
  logic [2:0]  pend;
  logic        busy;
  logic [2:0]  done;
  logic [2:0]  err;
  modport master (output host_wr, host_dataa, host_datab, force_all, ctl_rdy,
                  input ctl_dataa, ctl_datab, ctl_rst, pend, busy, done, err);
  modport slave (input host_wr, host_dataa, host_datab, force_all, ctl_rdy,
                 output ctl_dataa, ctl_datab, ctl_rst, pend, busy, done, err);
endinterface

// File: rtl/delay_prog_sched.sv
// delay_prog_sched: round-robin sequencer that loads one SY89297 delay programmer at a time
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : delay_prog_sched_if.slave (host writes, programmer data/start/ready, status)
//   Optional: define DELAY_SKIP_SAME_EN to suppress pend on rewrites of already-applied values
module delay_prog_sched #(
  parameter int RST_CYC   = 4,
  parameter int BLANK_CYC = 8,
  parameter int TIMEOUT   = 4096
) (
  input logic clk,
  input logic rst_n,
  delay_prog_sched_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, PULSE, BLANK, WAIT_RDY, FINISH} state_t;
  state_t      r_state, w_nxt;
  logic [1:0]  r_ch, r_ptr, w_sel;
  logic [15:0] r_cnt;
  logic        r_to, w_tout;
  logic [29:0] r_sha, r_shb, r_cta, r_ctb;
  logic [2:0]  r_pend, r_rst, r_done, r_err, w_oh, w_wr, w_set;
  assign w_oh   = 3'b001 << r_ch;
  assign w_tout = (r_state == WAIT_RDY) && !bus.ctl_rdy[r_ch] && (r_cnt == 16'(TIMEOUT - 1));
  assign w_set  = bus.force_all ? 3'b111 : w_wr;
`ifdef DELAY_SKIP_SAME_EN
  logic [29:0] r_lpa, r_lpb;
  always_comb begin
    for (int i = 0; i < 3; i++)
      w_wr[i] = bus.host_wr[i] &&
                ({bus.host_dataa[10*i +: 10], bus.host_datab[10*i +: 10]} != {r_lpa[10*i +: 10], r_lpb[10*i +: 10]} ||
                 {bus.host_dataa[10*i +: 10], bus.host_datab[10*i +: 10]} != {r_sha[10*i +: 10], r_shb[10*i +: 10]});
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lpa <= '0;
      r_lpb <= '0;
    end else if (r_state == LOAD) begin
      r_lpa[10*r_ch +: 10] <= r_sha[10*r_ch +: 10];
      r_lpb[10*r_ch +: 10] <= r_shb[10*r_ch +: 10];
    end
  end
`else
  assign w_wr = bus.host_wr;
`endif
  // First pending channel after the pointer wins; scan farthest-first so the nearest overrides.
  always_comb begin
    w_sel = r_ptr;
    for (int k = 3; k >= 1; k--)
      if (r_pend[(int'(r_ptr) + k) % 3]) w_sel = 2'((int'(r_ptr) + k) % 3);
  end
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:     w_nxt = |r_pend ? LOAD : IDLE;
      LOAD:     w_nxt = PULSE;
      PULSE:    w_nxt = (r_cnt == 16'(RST_CYC - 1)) ? BLANK : PULSE;
      BLANK:    w_nxt = (r_cnt == 16'(BLANK_CYC - 1)) ? WAIT_RDY : BLANK;
      WAIT_RDY: w_nxt = (bus.ctl_rdy[r_ch] || w_tout) ? FINISH : WAIT_RDY;
      FINISH:   w_nxt = IDLE;
      default:  w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_ch   <= '0;
      r_ptr  <= 2'd2;
      r_rst  <= '0;
      r_done <= '0;
      r_to   <= 1'b0;
      r_err  <= '0;
      r_pend <= '0;
      r_sha  <= '0;
      r_shb  <= '0;
      r_cta  <= '0;
      r_ctb  <= '0;
    end else begin
      r_cnt  <= (w_nxt != r_state) ? '0 : r_cnt + 16'(r_cnt != 16'hFFFF);
      r_ch   <= (r_state == IDLE) ? w_sel : r_ch;
      r_ptr  <= (r_state == FINISH) ? r_ch : r_ptr;
      r_rst  <= (w_nxt == PULSE) ? w_oh : '0;
      r_done <= (r_state == FINISH && !r_to) ? w_oh : '0;
      r_to   <= w_tout | (r_to & (r_state != IDLE));
      r_err  <= (r_err & ~bus.host_wr) | (w_tout ? w_oh : '0);
      r_pend <= (r_pend & ~((r_state == LOAD) ? w_oh : '0)) | w_set;
      for (int i = 0; i < 3; i++)
        if (bus.host_wr[i]) begin
          r_sha[10*i +: 10] <= bus.host_dataa[10*i +: 10];
          r_shb[10*i +: 10] <= bus.host_datab[10*i +: 10];
        end
      if (r_state == LOAD) begin
        r_cta[10*r_ch +: 10] <= r_sha[10*r_ch +: 10];
        r_ctb[10*r_ch +: 10] <= r_shb[10*r_ch +: 10];
      end
    end
  end
  assign bus.ctl_dataa = r_cta;
  assign bus.ctl_datab = r_ctb;
  assign bus.ctl_rst   = r_rst;
  assign bus.pend      = r_pend;
  assign bus.busy      = (r_state != IDLE);
  assign bus.done      = r_done;
  assign bus.err       = r_err;
endmodule

// File: tb/tb_delay_prog_sched.sv
// tb_delay_prog_sched: directed self-checking bench for delay_prog_sched
module tb_delay_prog_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [15:0] order;
  int overl;
  delay_prog_sched_if bus ();
  delay_prog_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    bus.host_wr = '0;
    bus.force_all = 1'b0;
    bus.ctl_rdy = 3'b111;
    tick(2);
    rst_n = 1'b1;
  endtask
  task automatic serve(input int max_cyc, output logic [15:0] ord, output int ov);
    int n = 0;
    ord = '0;
    ov = 0;
    while (1) begin
      tick(1);
      n++;
      if ((bus.ctl_rst & (bus.ctl_rst - 3'd1)) != 3'd0) ov++;
      if (bus.done != 3'd0)
        ord = {ord[11:0], (bus.done == 3'b001) ? 4'h1 : (bus.done == 3'b010) ? 4'h2 : (bus.done == 3'b100) ? 4'h3 : 4'hF};
      if (!bus.busy && bus.pend == 3'd0) break;
      if (n >= max_cyc) begin
        checks++;
        errors++;
        $error("FAIL serve_bound observed=busy%0b_pend%0b expected=idle within %0d cycles", bus.busy, bus.pend, max_cyc);
        break;
      end
    end
  endtask
  initial begin
    bus.host_wr = '0;
    bus.host_dataa = '0;
    bus.host_datab = '0;
    bus.force_all = 1'b0;
    bus.ctl_rdy = 3'b111;
    tick(1);
    chk("rst_ctl_rst", bus.ctl_rst, 0);
    chk("rst_pend", bus.pend, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_dataa", bus.ctl_dataa, 0);
    do_reset();
    bus.host_dataa = {20'h0, 10'h155};
    bus.host_datab = {20'h0, 10'h0AA};
    bus.host_wr = 3'b001;
    for (int c = 1; c <= 18; c++) begin
      tick(1);
      if (c == 1) begin
        bus.host_wr = '0;
        chk("t1_pend_set", bus.pend, 3'b001);
      end
      chk($sformatf("t1_rst_c%0d", c), bus.ctl_rst, (c >= 3 && c <= 6) ? 3'b001 : 3'b000);
      chk($sformatf("t1_done_c%0d", c), bus.done, (c == 17) ? 3'b001 : 3'b000);
      if (c == 3) begin
        chk("t1_dataa", bus.ctl_dataa, 30'h155);
        chk("t1_datab", bus.ctl_datab, 30'h0AA);
        chk("t1_pend_clr", bus.pend, 0);
      end
    end
    chk("t1_busy_end", bus.busy, 0);
    bus.host_wr = 3'b001;
    tick(1);
    bus.host_wr = '0;
`ifdef DELAY_SKIP_SAME_EN
    chk("same_pend", bus.pend, 3'b000);
    chk("same_busy", bus.busy, 0);
`else
    chk("same_pend", bus.pend, 3'b001);
    serve(100, order, overl);
    chk("same_order", order, 16'h1);
`endif
    do_reset();
    bus.force_all = 1'b1;
    tick(1);
    bus.force_all = 1'b0;
    chk("t2_pend", bus.pend, 3'b111);
    serve(200, order, overl);
    chk("t2_order", order, 16'h123);
    chk("t2_overlap", overl, 0);
    chk("t2_busy", bus.busy, 0);
    do_reset();
    bus.host_dataa = {10'h123, 10'h0AB, 10'h045};
    bus.host_datab = {10'h321, 10'h0BA, 10'h054};
    bus.host_wr = 3'b010;
    tick(1);
    bus.host_wr = '0;
    tick(4);
    chk("t3_rst_ch2", bus.ctl_rst, 3'b010);
    bus.host_wr = 3'b101;
    tick(1);
    bus.host_wr = '0;
    chk("t3_pend", bus.pend, 3'b101);
    serve(300, order, overl);
    chk("t3_order", order, 16'h231);
    chk("t3_overlap", overl, 0);
    chk("t3_dataa", bus.ctl_dataa, {10'h123, 10'h0AB, 10'h045});
    chk("t3_datab", bus.ctl_datab, {10'h321, 10'h0BA, 10'h054});
    do_reset();
    bus.ctl_rdy = 3'b101;
    bus.host_wr = 3'b010;
    tick(1);
    bus.host_wr = '0;
    tick(19);
    bus.host_wr = 3'b100;
    tick(1);
    bus.host_wr = '0;
    tick(4089);
    chk("t4_err_before", bus.err, 0);
    chk("t4_busy_wait", bus.busy, 1);
    tick(1);
    chk("t4_err_set", bus.err, 3'b010);
    chk("t4_done_none", bus.done, 0);
    serve(100, order, overl);
    chk("t4_order", order, 16'h3);
    chk("t4_err_sticky", bus.err, 3'b010);
    bus.host_wr = 3'b010;
    tick(1);
    bus.host_wr = '0;
    chk("t4_err_clr", bus.err, 0);
    do_reset();
    bus.ctl_rdy = 3'b110;
    bus.host_dataa = {20'h0, 10'h155};
    bus.host_datab = {20'h0, 10'h0AA};
    bus.host_wr = 3'b001;
    tick(1);
    bus.host_wr = '0;
    tick(19);
    bus.host_dataa = {20'h0, 10'h2CC};
    bus.host_datab = {20'h0, 10'h033};
    bus.host_wr = 3'b001;
    tick(1);
    bus.host_wr = '0;
    chk("t5_hold_a", bus.ctl_dataa, 30'h155);
    chk("t5_pend", bus.pend, 3'b001);
    tick(9);
    chk("t5_hold_b", bus.ctl_dataa, 30'h155);
    bus.ctl_rdy = 3'b111;
    tick(1);
    chk("t5_hold_fin", bus.ctl_dataa, 30'h155);
    serve(100, order, overl);
    chk("t5_order", order, 16'h11);
    chk("t5_new_a", bus.ctl_dataa, 30'h2CC);
    chk("t5_new_b", bus.ctl_datab, 30'h033);
    do_reset();
    bus.host_dataa = {10'h3A5, 20'h0};
    bus.host_datab = {10'h05A, 20'h0};
    bus.host_wr = 3'b100;
    tick(1);
    bus.host_wr = '0;
    tick(3);
    chk("t6_pulse", bus.ctl_rst, 3'b100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_ctl_rst", bus.ctl_rst, 0);
    chk("t6_busy", bus.busy, 0);
    chk("t6_pend", bus.pend, 0);
    chk("t6_dataa", bus.ctl_dataa, 0);
    chk("t6_done_err", {bus.done, bus.err}, 0);
    tick(1);
    rst_n = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
